// File: rtl/rv_common_pkg.sv
// rtl/rv_common_pkg.sv - shared constants for ready/valid datapath blocks
package rv_common_pkg;

  localparam logic MUX_MODE_FIXED     = 1'b0;
  localparam logic MUX_MODE_RR        = 1'b1;
  localparam int   DATA_WIDTH_DEFAULT = 64;

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - rotating-priority grant: first set req bit at or after ptr, wrapping
module rr_grant #(
  parameter int NUM_IN    = 8,
  parameter int SEL_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 grant_vld,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  logic [2*NUM_IN-1:0] req2;

  // Doubling req turns the wrapped scan into a plain search over positions >= ptr;
  // the upper copy guarantees a hit whenever any request is present.
  always_comb begin
    req2      = {req, req};
    grant_vld = |req;
    grant_idx = '0;
    for (int k = 2*NUM_IN-1; k >= 0; k--) begin
      if (req2[k] && (k >= int'(ptr))) begin
        grant_idx = (k >= NUM_IN) ? SEL_WIDTH'(k - NUM_IN) : SEL_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/rr_mux_n_1.sv
// rtl/rr_mux_n_1.sv - N:1 ready/valid selector, fixed or round-robin, registered output
module rr_mux_n_1
  import rv_common_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_IN     = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [SEL_WIDTH-1:0]         in_sel,
  input  logic                         in_mode,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic                  load_en;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  ptr_next;
  logic                  rr_vld;
  logic [SEL_WIDTH-1:0]  rr_idx;
  logic                  fixed_vld;
  logic                  grant_vld;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_grant #(
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_grant (
    .req       (in_valid),
    .ptr       (ptr),
    .grant_vld (rr_vld),
    .grant_idx (rr_idx)
  );

  assign load_en = ~out_valid | out_ready;

  // Index compare rather than in_valid[in_sel] so an out-of-range select never grants.
  always_comb begin
    fixed_vld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_WIDTH'(i)) fixed_vld = in_valid[i];
    end
  end

  always_comb begin
    grant_vld = rr_vld;
    grant_idx = rr_idx;
    if (in_mode == MUX_MODE_FIXED) begin
      grant_vld = fixed_vld;
      grant_idx = in_sel;
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        in_ready[i] = load_en & grant_vld;
        sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ptr_next = (grant_idx == SEL_WIDTH'(NUM_IN-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (load_en) begin
        if (grant_vld) begin
          out_valid <= 1'b1;
          out_data  <= sel_data;
          out_sel   <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (load_en && grant_vld && (in_mode == MUX_MODE_RR)) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n_1.sv
// tb/tb_rr_mux_n_1.sv - randomized and directed bench for rr_mux_n_1 against a behavioural model
module tb_rr_mux_n_1;

  localparam int N  = 8;
  localparam int DW = 64;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SW-1:0]   in_sel;
  logic            in_mode;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] chan [N];

  // Model state: what the consumer should see, and the round-robin start point.
  int            m_ptr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;

  rr_mux_n_1 #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_mode   (in_mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
  endtask

  // One cycle: drive inputs at negedge, check ready, then check registered outputs after the edge.
  task automatic step(input logic [N-1:0] v, input int s, input logic m, input logic ordy);
    int       gi;
    bit       gv;
    bit       le;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = chan[i];
    in_valid  = v;
    in_sel    = SW'(s);
    in_mode   = m;
    out_ready = ordy;
    le = !m_valid || ordy;
    gv = 0;
    gi = 0;
    if (!m) begin
      gi = s;
      gv = (s < N) && v[s];
    end else begin
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (m_ptr + j) % N;
        if (!gv && v[idx]) begin
          gv = 1;
          gi = idx;
        end
      end
    end
    exp_rdy = (le && gv) ? N'(1 << gi) : '0;
    #1;
    check("in_ready", DW'(in_ready), DW'(exp_rdy));
    @(posedge clk);
    if (le) begin
      if (gv) begin
        m_valid = 1;
        m_data  = chan[gi];
        m_sel   = gi;
      end else begin
        m_valid = 0;
      end
      if (gv && m) m_ptr = (gi + 1) % N;
    end
    #1;
    check("out_valid", DW'(out_valid), DW'(m_valid));
    check("out_data", out_data, m_data);
    check("out_sel", DW'(out_sel), DW'(m_sel));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) chan[i] = {32'hC0DE_0000, 32'(i)};
    chan[3]   = 64'hDEAD_BEEF_0000_0003;
    in_data   = '0;
    in_valid  = '0;
    in_sel    = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_sel", DW'(out_sel), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed select of channel 3, then a select whose channel is idle.
    step(8'h08, 3, 1'b0, 1'b1);
    check("fixed_sel3", DW'(out_sel), DW'(3));
    check("fixed_data3", out_data, 64'hDEAD_BEEF_0000_0003);
    step(8'h08, 5, 1'b0, 1'b1);
    check("fixed_idle_valid", DW'(out_valid), '0);

    // All channels requesting: strict rotation with one beat per cycle.
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 0, 1'b1, 1'b1);
      check("rr_seq", DW'(out_sel), DW'(k % N));
      check("rr_tput", DW'(out_valid), DW'(1));
    end

    // Park pointer at 1, then only channels 0 and 7 request.
    step(8'h01, 0, 1'b1, 1'b1);
    step(8'h81, 0, 1'b1, 1'b1);
    check("rr_edge_a", DW'(out_sel), DW'(7));
    step(8'h81, 0, 1'b1, 1'b1);
    check("rr_edge_b", DW'(out_sel), DW'(0));
    step(8'h81, 0, 1'b1, 1'b1);
    check("rr_edge_c", DW'(out_sel), DW'(7));

    // Backpressure then simultaneous drain and reload.
    step(8'h01, 0, 1'b0, 1'b1);
    chan[0] = 64'h1111_2222_3333_4444;
    for (int k = 0; k < 4; k++) begin
      step(8'h01, 0, 1'b0, 1'b0);
      check("stall_ready", DW'(in_ready), '0);
    end
    step(8'h01, 0, 1'b0, 1'b1);
    check("reload_valid", DW'(out_valid), DW'(1));
    check("reload_data", out_data, 64'h1111_2222_3333_4444);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) chan[i] = {$urandom, $urandom};
      step(N'($urandom), int'($urandom_range(0, N-1)), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-stream with a held beat.
    step(8'hFF, 0, 1'b1, 1'b0);
    step(8'hFF, 0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_out_valid", DW'(out_valid), '0);
    check("async_out_data", out_data, '0);
    check("async_out_sel", DW'(out_sel), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h24, 0, 1'b1, 1'b1);
    check("post_reset_rr", DW'(out_sel), DW'(2));

    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < N; i++) chan[i] = {$urandom, $urandom};
      step(N'($urandom), int'($urandom_range(0, N-1)), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_n_1.md
Name: rr_mux_n_1

Overview:
- Parametrised N:1 data selector with per-channel valid/ready handshakes and a registered output stage.
- Supports two modes:
  - fixed-select: the index comes from in_sel.
  - round-robin: a rotating-priority arbiter picks the channel.
- Used wherever several producers share one 64-bit datapath consumer, e.g. writeback-port sharing or the memory request path.
- Replaces unregistered 8:1 selection where backpressure and fairness are needed.

Parameters:
- DATA_WIDTH, 64, width of each data channel.
- NUM_IN, 8, number of input channels; legal range 2..16.
- SEL_WIDTH, $clog2(NUM_IN), width of the select and grant index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*DATA_WIDTH  flattened inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; at most one bit set per cycle.
- in_sel  in  SEL_WIDTH  channel index, used in mode 0 only.
- in_mode  in  1  0 = fixed select, 1 = round-robin.
- out_data  out  DATA_WIDTH  registered selected data.
- out_sel  out  SEL_WIDTH  index of the channel that supplied out_data.
- out_valid  out  1  out_data holds an unconsumed beat.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync deassert handled at top level):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - A beat held at reset is discarded, not replayed.
- Transfers:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at a rising edge.
  - Output transfer: out_valid && out_ready.
- Output-stage load enable: load_en = ~out_valid | out_ready.
  - Full-throughput pipeline: a new beat can load in the same cycle the held beat drains.
- Grant, combinational, produces grant_vld and grant_idx:
  - Mode 0: grant_vld = (in_sel < NUM_IN) && in_valid[in_sel]; grant_idx = in_sel. An out-of-range in_sel never grants.
  - Mode 1: grant_idx is the first i with in_valid[i] set, scanning ptr, ptr+1, … NUM_IN-1, 0, … ptr-1 (wraps). grant_vld = |in_valid.
- in_ready[i] = load_en && grant_vld && (grant_idx == i); all other bits are 0.
  - in_ready may depend combinationally on in_valid, in_sel, in_mode and out_ready.
  - No valid-to-ready loop is required by producers.
- On a rising edge with load_en:
  - If grant_vld: out_data ← channel grant_idx; out_sel ← grant_idx; out_valid ← 1.
  - Else: out_valid ← 0; out_data and out_sel hold.
- Without load_en, out_data, out_sel and out_valid hold (stable while stalled).
- ptr update:
  - Only on an input transfer in mode 1: ptr ← (grant_idx+1) mod NUM_IN. Wrap from NUM_IN-1 to 0.
  - In mode 0, ptr holds.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Mode switch:
  - Takes effect in the same cycle as the new in_mode value.
  - ptr is preserved across switches.
  - An already-held output beat is unaffected.
- Simultaneous drain and load: the held beat is accepted downstream and the new beat is captured on the same edge; out_valid stays 1.
- Channel drops valid while not granted: no state change; the protocol does not require producers to hold valid.

Decomposition:
- Shared package (rv_common_pkg):
  - MUX_MODE_FIXED = 1'b0, MUX_MODE_RR = 1'b1 constants.
  - DATA_WIDTH_DEFAULT = 64.
- Sub-module rr_grant (params NUM_IN, SEL_WIDTH):
  - Inputs: req vector, ptr.
  - Outputs: grant_vld, grant_idx.
  - Implementation: double-width masked priority find.
  - Verified standalone with exhaustive req × ptr for NUM_IN=8.

Test Plan:
1. Reset, then mode 0, in_sel=3, in_valid=8'h08, ch3=64'hDEAD_BEEF_0000_0003, out_ready=1 → in_ready=8'h08; next cycle out_valid=1, out_data=ch3, out_sel=3.
2. Mode 0, in_sel=5, in_valid=8'h08 → in_ready=0; out_valid falls to 0 the cycle after.
3. Mode 1, in_valid=8'hFF continuously, out_ready=1 → out_sel sequence 0,1,…,7,0 (wraps); one beat every cycle.
4. Mode 1, in_valid=8'h81, ptr=1 → grants 7 then 0 then 7; channels 1–6 never granted.
5. Backpressure: out_valid=1, out_ready=0 for 4 cycles with in_valid=8'h01 → in_ready=0; out_data/out_sel stable. Raise out_ready → drain and reload on the same edge; out_valid stays 1.
6. Assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, ptr=0 immediately (async); the first round-robin grant after release is the lowest valid index.
